// File: rtl/ss2bcd_capture.sv
// Display-bus monitor: samples the active-low segment/strobe bus, waits for each digit to
// settle, decodes it back to BCD and publishes complete 4-digit frames with dot and error status.
module ss2bcd_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [1:0]  dot_pos,
    output logic        dot_valid,
    output logic        code_err,
    output logic        frame_valid,
    output logic        timeout
);
    localparam int SW = $clog2(STABLE_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [SW-1:0] STABLE_MATCH = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {COLLECT, PUBLISH} state_t;

    function automatic logic [3:0] decode_seg(input logic [6:0] code);
        logic [3:0] bcd;
        case (code)
            7'b1000000: bcd = 4'd0;
            7'b1001111: bcd = 4'd1;
            7'b0100100: bcd = 4'd2;
            7'b0000110: bcd = 4'd3;
            7'b0001011: bcd = 4'd4;
            7'b0010010: bcd = 4'd5;
            7'b0010000: bcd = 4'd6;
            7'b1000111: bcd = 4'd7;
            7'b0000000: bcd = 4'd8;
            7'b0000010: bcd = 4'd9;
            default:    bcd = 4'hF;
        endcase
        return bcd;
    endfunction

    function automatic logic [1:0] encode_onehot(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    logic [7:0]    seg_q;
    logic [7:0]    seg_prev;
    logic [3:0]    an_q;
    logic [3:0]    an_prev;
    logic [SW-1:0] stab_cnt;
    logic [SW-1:0] stab_next;

    // Input registers reset to the idle bus so that reset never looks like a strobed digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q    <= '1;
            an_q     <= '1;
            seg_prev <= '1;
            an_prev  <= '1;
            stab_cnt <= '0;
        end else begin
            seg_q    <= seg;
            an_q     <= an;
            seg_prev <= seg_q;
            an_prev  <= an_q;
            stab_cnt <= stab_next;
        end
    end

    logic       sample_changed;
    logic       capture;
    logic       strobe_blank;
    logic       strobe_single;
    logic       cap_valid;
    logic       cap_illegal;
    logic [1:0] cap_slot;
    logic [3:0] cap_bit;
    logic [3:0] cap_code;
    logic       cap_bad;
    logic       cap_dot;

    always_comb begin
        sample_changed = ({seg_q, an_q} != {seg_prev, an_prev});
        if (sample_changed) begin
            stab_next = SW'(1);
        end else if (stab_cnt == '1) begin
            stab_next = stab_cnt;
        end else begin
            stab_next = stab_cnt + SW'(1);
        end
        // The counter width exceeds STABLE_CYCLES, so each stable run passes the match exactly once.
        capture       = (stab_next == STABLE_MATCH);
        strobe_blank  = (an_q == 4'hF);
        strobe_single = $onehot(~an_q);
        cap_valid     = capture && strobe_single;
        cap_illegal   = capture && !strobe_blank && !strobe_single;
        cap_bit       = ~an_q;
        cap_slot      = encode_onehot(~an_q);
        cap_code      = decode_seg(seg_q[6:0]);
        cap_bad       = (cap_code == 4'hF);
        cap_dot       = !seg_q[7];
    end

    state_t        state;
    state_t        state_n;
    logic [3:0]    mask;
    logic [3:0]    mask_n;
    logic [15:0]   stage;
    logic [15:0]   stage_n;
    logic [3:0]    dot_set;
    logic [3:0]    dot_n;
    logic          err_acc;
    logic          err_n;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_n;
    logic [15:0]   digits_n;
    logic [1:0]    dot_pos_n;
    logic          dot_valid_n;
    logic          code_err_n;
    logic          frame_valid_n;
    logic          timeout_n;
    logic          expire;
    logic          complete;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n       = state;
        mask_n        = mask;
        stage_n       = stage;
        dot_n         = dot_set;
        err_n         = err_acc;
        tmo_n         = tmo_cnt;
        digits_n      = digits;
        dot_pos_n     = dot_pos;
        dot_valid_n   = dot_valid;
        code_err_n    = code_err;
        frame_valid_n = 1'b0;
        timeout_n     = 1'b0;
        expire        = 1'b0;
        complete      = 1'b0;

        if (state == PUBLISH) begin
            digits_n      = stage;
            dot_valid_n   = $onehot(dot_set);
            dot_pos_n     = $onehot(dot_set) ? encode_onehot(dot_set) : 2'd0;
            code_err_n    = err_acc;
            frame_valid_n = 1'b1;
            mask_n        = 4'h0;
            dot_n         = 4'h0;
            err_n         = 1'b0;
            tmo_n         = '0;
            state_n       = COLLECT;
        end else if (mask != 4'h0 && mask != 4'hF) begin
            tmo_n  = tmo_cnt + TW'(1);
            expire = (tmo_cnt == TIMEOUT_LAST);
        end

        // A capture that finishes the frame wins over an expiring timeout.
        complete = cap_valid && ((mask_n | cap_bit) == 4'hF);
        if (expire && !complete) begin
            timeout_n = 1'b1;
            mask_n    = 4'h0;
            dot_n     = 4'h0;
            err_n     = 1'b0;
            tmo_n     = '0;
        end

        if (cap_valid) begin
            stage_n[{cap_slot, 2'b00} +: 4] = cap_code;
            if (cap_bad) begin
                err_n = 1'b1;
            end
            if (cap_dot && ((dot_n & ~cap_bit) != 4'h0)) begin
                err_n = 1'b1;
            end
            dot_n  = cap_dot ? (dot_n | cap_bit) : (dot_n & ~cap_bit);
            mask_n = mask_n | cap_bit;
        end
        if (cap_illegal) begin
            err_n = 1'b1;
        end
        if (complete) begin
            state_n = PUBLISH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask        <= 4'h0;
            stage       <= 16'h0;
            dot_set     <= 4'h0;
            err_acc     <= 1'b0;
            tmo_cnt     <= '0;
            digits      <= 16'h0;
            dot_pos     <= 2'd0;
            dot_valid   <= 1'b0;
            code_err    <= 1'b0;
            frame_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            mask        <= mask_n;
            stage       <= stage_n;
            dot_set     <= dot_n;
            err_acc     <= err_n;
            tmo_cnt     <= tmo_n;
            digits      <= digits_n;
            dot_pos     <= dot_pos_n;
            dot_valid   <= dot_valid_n;
            code_err    <= code_err_n;
            frame_valid <= frame_valid_n;
            timeout     <= timeout_n;
        end
    end
endmodule
